// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the memory-mapped UART controller.
//   - Register offsets on the 2-bit bus address.
//   - STATUS register bit positions.
//   - Default baud divisor: 100 MHz / 115200.
package uart_ctrl_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_DIV    = 2'd3;

  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_RX_FULL     = 1;
  localparam int unsigned ST_TX_EMPTY    = 2;
  localparam int unsigned ST_TX_FULL     = 3;
  localparam int unsigned ST_RX_OVF      = 4;
  localparam int unsigned ST_TX_OVF      = 5;
  localparam int unsigned ST_RX_CNT_LSB  = 8;

  localparam logic [15:0] UART_DIV_RESET = 16'd868;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
//   clk, rstn   : clock, asynchronous active-low reset
//   push, din   : write request and data; ignored when full unless a pop also happens
//   pop         : read request; ignored when empty
//   dout        : head entry (storage is reset to zero, so dout reads 0 after reset)
//   count       : number of stored entries, full/empty flags
module uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a valid pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push) mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller between the CPU data bus and the tx/rx serializer cores.
//   clk, rstn          : clock, asynchronous active-low reset
//   sel, we, addr,     : single-cycle bus access; DATA(0) STATUS(1) CTRL(2) DIV(3)
//   wdata, rdata       : rdata is registered and holds until the next read
//   irq                : registered level interrupt
//   tx_data/valid/ready: TX FIFO head towards the transmitter core
//   rx_data/valid      : one-cycle byte pulses from the receiver core
//   baud_div           : divisor shared by both cores
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = UART_DIV_RESET,
  parameter logic [15:0] DIV_MIN    = 16'd4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] baud_div
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    rx_dout;
  logic          rd_req, wr_req;
  logic          tx_push, tx_pop, tx_drop;
  logic          rx_pop, rx_drop;
  logic          w1c_status;
  logic [15:0]   status;

  logic [15:0] rdata_q, rdata_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        irq_q, irq_d;

  assign rd_req     = sel & ~we;
  assign wr_req     = sel & we;
  assign tx_push    = wr_req & (addr == UART_DATA);
  assign tx_pop     = ~tx_empty & tx_ready;
  assign tx_drop    = tx_push & tx_full & ~tx_pop;
  assign rx_pop     = rd_req & (addr == UART_DATA) & ~rx_empty;
  assign rx_drop    = rx_valid & rx_full & ~rx_pop;
  assign w1c_status = wr_req & (addr == UART_STATUS);

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wdata[7:0]),
    .dout  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    status = '0;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_RX_FULL]     = rx_full;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_RX_OVF]      = rx_ovf_q;
    status[ST_TX_OVF]      = tx_ovf_q;
    status[ST_RX_CNT_LSB +: 8] = 8'(rx_count);
  end

  always_comb begin
    rdata_d = rdata_q;
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    if (rd_req) begin
      case (addr)
        UART_DATA:   rdata_d = rx_empty ? 16'h0000 : {8'h00, rx_dout};
        UART_STATUS: rdata_d = status;
        UART_CTRL:   rdata_d = {14'b0, ctrl_q};
        default:     rdata_d = div_q;
      endcase
    end
    if (wr_req && addr == UART_CTRL) ctrl_d = wdata[1:0];
    if (wr_req && addr == UART_DIV)  div_d  = (wdata < DIV_MIN) ? DIV_MIN : wdata;
    // New overflow events take priority over a simultaneous W1C.
    rx_ovf_d = (rx_ovf_q & ~(w1c_status & wdata[ST_RX_OVF])) | rx_drop;
    tx_ovf_d = (tx_ovf_q & ~(w1c_status & wdata[ST_TX_OVF])) | tx_drop;
    irq_d    = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q  <= '0;
      ctrl_q   <= '0;
      div_q    <= DIV_RESET;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata    = rdata_q;
  assign irq      = irq_q;
  assign tx_valid = ~tx_empty;
  assign baud_div = div_q;

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Memory-mapped UART controller between the zktc CPU data bus and the UART tx/rx serializer cores on the Arty S7 top.
- Buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO.
- Holds the baud divisor, reports status and overflow, and raises a level interrupt.
- Lets firmware run loopback and console traffic without polling every bit time.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO; power of two, at least 2.
- DIV_RESET, 868, reset baud divisor: 100 MHz / 115200.
- DIV_MIN, 4, smallest divisor ever presented to the cores.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- sel  in  1  bus access strobe, one cycle per access
- we  in  1  1 = write, 0 = read; qualified by sel
- addr  in  2  register offset
- wdata  in  16  write data
- rdata  out  16  read data, valid the cycle after a read
- irq  out  1  level interrupt to CPU
- tx_data  out  8  byte to transmitter core
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  transmitter accepts byte
- rx_data  in  8  byte from receiver core
- rx_valid  in  1  one-cycle pulse, no backpressure
- baud_div  out  16  divisor to both cores

Interface note: one clock, clk; reset rstn, asynchronous, active-low.

Behaviour:
- Reset values: both FIFOs empty; tx_valid=0; tx_data=0; rdata=0; irq=0; status sticky bits 0; CTRL=0; baud_div=DIV_RESET.
- Register map:
  - 0 DATA: write pushes wdata[7:0] to TX FIFO; read pops RX FIFO.
  - 1 STATUS (read): bit0 rx_nonempty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_ovf, bit5 tx_ovf, bits[15:8] rx_count. Write-1-to-clear on bits 4/5; other bits ignore writes.
  - 2 CTRL: bit0 rx_ie, bit1 tx_ie; other bits read 0.
  - 3 DIV: baud divisor.
- Reads:
  - rdata is registered; one cycle latency after sel&!we.
  - rdata holds its value until the next read.
- DATA read:
  - RX non-empty: returns {8'h00, head} and pops.
  - RX empty: returns 16'h0000, no pop, no error.
- DATA write with TX full:
  - Byte is dropped and tx_ovf is set.
  - Exception: tx_valid&tx_ready in the same cycle pops the head, so the push is accepted and the count is unchanged.
- TX side:
  - tx_valid = TX count != 0; tx_data = head entry.
  - Pop on tx_valid&tx_ready. tx_data changes only after a pop or a push into an empty FIFO.
- RX side:
  - rx_valid pushes rx_data.
  - RX full: byte dropped, rx_ovf set.
  - Exception: a CPU DATA read pops in the same cycle, so the byte is accepted and the count is unchanged.
- Sticky bits: set and W1C-clear in the same cycle → set wins.
- DIV write: values below DIV_MIN are stored as DIV_MIN. baud_div updates the cycle after the write. Mid-frame changes are not protected; firmware writes DIV only when tx_empty and idle.
- irq = (rx_ie & rx_nonempty) | (tx_ie & tx_empty). Registered, one cycle after the causing state change.
- FIFO pointers: log2(FIFO_DEPTH) bits, wrap modulo depth. Count is log2+1 bits; full when count == FIFO_DEPTH.
- No-sel cycles: no register side effects.
- rstn asserted mid-transfer: all state returns to reset values immediately. A byte the core has already accepted is not the controller's concern.

Decomposition:
- Package uart_ctrl_pkg:
  - register offset constants UART_DATA/STATUS/CTRL/DIV;
  - STATUS bit index constants;
  - DIV_RESET default.
- Sub-module uart_fifo: synchronous FIFO, instantiated twice.
  - Ports: clk, rstn, push, pop, din, dout, count, full, empty.
  - Simultaneous push/pop when full or empty handled inside the FIFO.

Test Plan:
- Reset, then read STATUS → rdata=16'h0004 (tx_empty only); baud_div=868; irq=0.
- Write DATA 0x41,0x42,0x43 with tx_ready=0 → tx_valid=1, tx_data=0x41. Raise tx_ready for 3 cycles → tx_data 0x42, then 0x43, then tx_valid=0.
- With tx_ready=0, write 9 bytes to DATA → STATUS reads 0x0028 (tx_full, tx_ovf). W1C write 0x0020 → STATUS 0x0008.
- Pulse rx_valid with 0x5A then 0xA5 → STATUS rx_count=2. DATA reads return 0x005A then 0x00A5; a third DATA read returns 0x0000.
- CTRL=0x0001 with RX empty → irq=0. One rx_valid pulse → irq=1 a cycle later. DATA read → irq=0.
- Fill RX to 8, then pulse rx_valid and read DATA in the same cycle → no rx_ovf, count stays 8.
- Write DIV=2 → baud_div=4.
- Assert rstn=0 mid-stream → FIFOs empty and baud_div=868 with no clock edge.
